// File: rtl/mul16_pkg.sv
// Shared types, widths and the round-robin pick function for the shared-multiplier scheduler.
package mul16_pkg;

    localparam int OP_W      = 16;
    localparam int RES_W     = 32;
    localparam int CNT_W     = 16;
    localparam int MAX_REQ   = 8;
    localparam int PTR_MAX_W = 3;

    // One-hot grant for the first set bit of valid, scanning ptr, ptr+1, ... modulo n.
    function automatic logic [MAX_REQ-1:0] rr_pick(input logic [MAX_REQ-1:0]   valid,
                                                   input logic [PTR_MAX_W-1:0] ptr,
                                                   input int                   n);
        logic [MAX_REQ-1:0] gnt;
        logic               found;
        int                 idx;
        gnt   = '0;
        found = 1'b0;
        for (int i = 0; i < MAX_REQ; i++) begin
            if (i < n && !found) begin
                idx = (int'(ptr) + i) % n;
                if (valid[idx]) begin
                    gnt[idx] = 1'b1;
                    found    = 1'b1;
                end
            end
        end
        return gnt;
    endfunction

endpackage

// File: rtl/Mul_16b.sv
// Combinational 16x16 unsigned multiplier with a full 32-bit product.
module Mul_16b (
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic [31:0] p
);

    assign p = 32'(a) * 32'(b);

endmodule

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant from the priority pointer, pointer advances past each winner.
module rr_arbiter
    import mul16_pkg::*;
#(
    parameter int N_REQ = 4,
    localparam int PTR_W = $clog2(N_REQ)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [N_REQ-1:0] req,
    output logic [N_REQ-1:0] gnt,
    output logic [PTR_W-1:0] ptr
);

    logic [MAX_REQ-1:0] pick;
    logic [PTR_W-1:0]   ptr_nxt;
    logic               unused_pick;

    // Grant selection; nothing is granted while en is low.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        pick = '0;
        if (en) pick = rr_pick(MAX_REQ'(req), PTR_MAX_W'(ptr), N_REQ);
    end

    assign gnt         = pick[N_REQ-1:0];
    assign unused_pick = ^pick;

    // Next pointer: one past the granted index, wrapping at N_REQ; holds without a grant.
    always_comb begin
        ptr_nxt = ptr;
        for (int i = 0; i < N_REQ; i++) begin
            if (gnt[i]) ptr_nxt = (i == N_REQ - 1) ? '0 : PTR_W'(i + 1);
        end
    end

    // Priority pointer register.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
        if (!rst_n) ptr <= '0;
        else        ptr <= ptr_nxt;
    end

endmodule

// File: rtl/mul16_rr_sched.sv
// Round-robin scheduler sharing one 16x16 multiplier between N_REQ requesters, fixed 2-cycle latency.
module mul16_rr_sched
    import mul16_pkg::*;
#(
    parameter int N_REQ = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic [N_REQ-1:0]      req_valid,
    input  logic [N_REQ*OP_W-1:0] req_a,
    input  logic [N_REQ*OP_W-1:0] req_b,
    output logic [N_REQ-1:0]      req_ready,
    output logic [N_REQ-1:0]      rsp_valid,
    output logic [RES_W-1:0]      rsp_data,
    output logic                  busy,
    output logic [CNT_W-1:0]      ops_cnt
);

    localparam int PTR_W = $clog2(N_REQ);

    logic [N_REQ-1:0] gnt;
    logic [PTR_W-1:0] unused_arb_ptr;
    logic [OP_W-1:0]  mux_a, mux_b;
    logic             s1_v, s2_v;
    logic [N_REQ-1:0] s1_tag, s2_tag;
    logic [OP_W-1:0]  s1_a, s1_b;
    logic [RES_W-1:0] prod, s2_data;

    rr_arbiter #(.N_REQ(N_REQ)) u_arb (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (en),
        .req   (req_valid),
        .gnt   (gnt),
        .ptr   (unused_arb_ptr)
    );

    assign req_ready = gnt;

    // Operand mux: select the granted requester's operand slice.
    always_comb begin
        mux_a = '0;
        mux_b = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (gnt[i]) begin
                mux_a = req_a[i*OP_W +: OP_W];
                mux_b = req_b[i*OP_W +: OP_W];
            end
        end
    end

    // Issue stage control: valid and one-hot tag of the accepted request.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_v   <= 1'b0;
            s1_tag <= '0;
        end else begin
            s1_v   <= |gnt;
            s1_tag <= gnt;
        end
    end

    // Issue stage operands, captured only on a handshake.
    // NOTE: pure datapath registers are left unreset; s1_v qualifies them, so reset buys nothing.
    always_ff @(posedge clk) begin
        if (|gnt) begin
            s1_a <= mux_a;
            s1_b <= mux_b;
        end
    end

    Mul_16b u_mul (
        .a (s1_a),
        .b (s1_b),
        .p (prod)
    );

    // Result stage: product and tag load only for a valid issue so rsp_data holds otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_v    <= 1'b0;
            s2_tag  <= '0;
            s2_data <= '0;
        end else begin
            s2_v <= s1_v;
            if (s1_v) begin
                s2_tag  <= s1_tag;
                s2_data <= prod;
            end
        end
    end

    // Completed-operation counter, wraps naturally at 2^16.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)    ops_cnt <= '0;
        else if (s2_v) ops_cnt <= ops_cnt + 1'b1;
    end

    assign rsp_valid = s2_v ? s2_tag : '0;
    assign rsp_data  = s2_data;
    assign busy      = s1_v | s2_v;

endmodule

// File: tb/tb_mul16_rr_sched.sv
// Self-checking bench for mul16_rr_sched: randomized stimulus against a queue-based reference model.
module tb_mul16_rr_sched;

    localparam int N = 4;

    logic            clk;
    logic            rst_n;
    logic            en;
    logic [N-1:0]    req_valid;
    logic [N*16-1:0] req_a;
    logic [N*16-1:0] req_b;
    logic [N-1:0]    req_ready;
    logic [N-1:0]    rsp_valid;
    logic [31:0]     rsp_data;
    logic            busy;
    logic [15:0]     ops_cnt;

    mul16_rr_sched #(.N_REQ(N)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .req_valid (req_valid),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_data  (rsp_data),
        .busy      (busy),
        .ops_cnt   (ops_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: pending results keyed by the cycle they must appear in.
    typedef struct {
        int          due;
        int          idx;
        logic [31:0] prod;
    } pend_t;

    pend_t       pq[$];
    int          m_ptr;
    logic [15:0] m_cnt;
    int          cyc;
    int          n_checks;
    int          n_errors;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [15:0] opa(input int i);
        return req_a[i*16 +: 16];
    endfunction

    function automatic logic [15:0] opb(input int i);
        return req_b[i*16 +: 16];
    endfunction

    task automatic set_ops(input int i, input logic [15:0] a, input logic [15:0] b);
        req_a[i*16 +: 16] = a;
        req_b[i*16 +: 16] = b;
    endtask

    task automatic rand_ops(input int i);
        set_ops(i, 16'($urandom), 16'($urandom));
    endtask

    // Check one cycle's outputs against the model, then advance to the next cycle.
    // Inputs must be set before calling (while clk is low).
    task automatic cycle(output int g);
        logic [N-1:0] exp_rdy;
        logic [N-1:0] exp_rv;
        #1;
        exp_rdy = '0;
        g       = -1;
        if (en) begin
            for (int k = 0; k < N; k++) begin
                int j;
                j = (m_ptr + k) % N;
                if (g < 0 && req_valid[j]) g = j;
            end
        end
        if (g >= 0) exp_rdy[g] = 1'b1;
        check("req_ready", 64'(req_ready), 64'(exp_rdy));

        exp_rv = '0;
        if (pq.size() > 0 && pq[0].due == cyc) begin
            exp_rv[pq[0].idx] = 1'b1;
            check("rsp_data", 64'(rsp_data), 64'(pq[0].prod));
        end
        check("rsp_valid", 64'(rsp_valid), 64'(exp_rv));
        check("busy", 64'(busy), 64'(pq.size() > 0));
        check("ops_cnt", 64'(ops_cnt), 64'(m_cnt));

        if (exp_rv != 0) begin
            void'(pq.pop_front());
            m_cnt = m_cnt + 16'd1;
        end
        if (g >= 0) begin
            pq.push_back('{due: cyc + 2, idx: g, prod: 32'(opa(g)) * 32'(opb(g))});
            m_ptr = (g + 1) % N;
        end
        @(posedge clk);
        @(negedge clk);
        cyc++;
    endtask

    // Asynchronous reset pulse inside the low clock phase; everything in flight is discarded.
    task automatic do_reset();
        req_valid = '0;
        rst_n     = 1'b0;
        #1;
        check("rst_rsp_valid", 64'(rsp_valid), 64'(0));
        check("rst_rsp_data", 64'(rsp_data), 64'(0));
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_ops_cnt", 64'(ops_cnt), 64'(0));
        check("rst_req_ready", 64'(req_ready), 64'(0));
        pq.delete();
        m_ptr = 0;
        m_cnt = '0;
        #1 rst_n = 1'b1;
        @(posedge clk);
        @(negedge clk);
        cyc++;
    endtask

    initial begin
        int g;
        int exp_seq[8];
        n_checks  = 0;
        n_errors  = 0;
        cyc       = 0;
        m_ptr     = 0;
        m_cnt     = '0;
        rst_n     = 1'b0;
        en        = 1'b0;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        @(negedge clk);
        do_reset();

        // Single request from requester 0: 3 * 5.
        en = 1'b1;
        set_ops(0, 16'd3, 16'd5);
        req_valid = 4'b0001;
        cycle(g);
        req_valid = '0;
        cycle(g);
        #1;
        check("single_rsp_valid", 64'(rsp_valid), 64'(4'b0001));
        check("single_rsp_data", 64'(rsp_data), 64'(32'd15));
        cycle(g);
        #1;
        check("single_ops_cnt", 64'(ops_cnt), 64'(16'd1));

        // Edge operands from requester 2.
        set_ops(2, 16'hFFFF, 16'hFFFF);
        req_valid = 4'b0100;
        cycle(g);
        set_ops(2, 16'h0000, 16'h1234);
        cycle(g);
        req_valid = '0;
        cycle(g);
        #1;
        check("edge_zero", 64'(rsp_data), 64'(0));
        for (int i = 0; i < 2; i++) cycle(g);

        // All four valid continuously from reset: grants 0,1,2,3,0,1,2,3.
        do_reset();
        en = 1'b1;
        for (int i = 0; i < N; i++) rand_ops(i);
        req_valid = 4'b1111;
        exp_seq = '{0, 1, 2, 3, 0, 1, 2, 3};
        for (int i = 0; i < 8; i++) begin
            cycle(g);
            check("rr_order", 64'(g), 64'(exp_seq[i]));
            if (g >= 0) rand_ops(g);
        end
        req_valid = '0;
        for (int i = 0; i < 3; i++) cycle(g);

        // Move the pointer to 2 with a lone grant to requester 1, then 1 and 3 alternate from 3.
        rand_ops(1);
        req_valid = 4'b0010;
        cycle(g);
        rand_ops(1);
        rand_ops(3);
        req_valid = 4'b1010;
        for (int i = 0; i < 6; i++) begin
            cycle(g);
            check("alt_order", 64'(g), 64'((i % 2 == 0) ? 3 : 1));
            if (g >= 0) rand_ops(g);
        end
        // Grant enable low for two cycles: no grants, pipeline drains.
        en = 1'b0;
        for (int i = 0; i < 2; i++) cycle(g);
        #1;
        check("en_low_busy", 64'(busy), 64'(0));
        en = 1'b1;
        for (int i = 0; i < 2; i++) begin
            cycle(g);
            if (g >= 0) rand_ops(g);
        end

        // Reset while both pipeline stages hold operations.
        req_valid = 4'b1111;
        for (int i = 0; i < 3; i++) begin
            cycle(g);
            if (g >= 0) rand_ops(g);
        end
        #1;
        check("pre_rst_busy", 64'(busy), 64'(1));
        do_reset();
        req_valid = 4'b1110;
        cycle(g);
        check("post_rst_first", 64'(g), 64'(1));
        req_valid = '0;
        for (int i = 0; i < 3; i++) cycle(g);

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            en        = ($urandom_range(0, 7) != 0);
            req_valid = 4'($urandom);
            for (int r = 0; r < N; r++) begin
                if ($urandom_range(0, 3) == 0) rand_ops(r);
            end
            cycle(g);
        end
        req_valid = '0;
        for (int i = 0; i < 3; i++) cycle(g);

        // Counter wrap: 65534 operations, then 2 more.
        do_reset();
        en        = 1'b1;
        req_valid = 4'b0001;
        for (int i = 0; i < 65536; i++) begin
            rand_ops(0);
            cycle(g);
        end
        req_valid = '0;
        cycle(g);
        #1;
        check("wrap_ffff", 64'(ops_cnt), 64'(16'hFFFF));
        cycle(g);
        #1;
        check("wrap_0000", 64'(ops_cnt), 64'(16'h0000));
        cycle(g);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
